uart_rx_word_fifo: RTL and testbench
====================================

Name: uart_rx_word_fifo

Overview:
- Sits directly downstream of the UART receiver. Consumes its one-cycle byte strobes and packs every 4 bytes into a 32-bit word.
- Words are buffered in a first-word-fall-through FIFO, which the core / program loader drains with a valid/ready handshake.
- Framing errors and overflows are recorded in sticky flags. Corrupt partial words are discarded.

Parameters:
- DEPTH, 16: FIFO depth in 32-bit words; power of two, ≥2.
- BIG_ENDIAN, 0: 0 places the first received byte in word_data[7:0]; 1 places it in word_data[31:24].

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe: byte available.
- rx_ferr  in  1  framing error; qualifies the same-cycle rx_valid.
- clear  in  1  synchronous flush of the FIFO, the partial word and the sticky flags.
- word_data  out  32  FIFO head word; valid when word_valid=1.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts the head word when word_valid=1.
- count  out  $clog2(DEPTH)+1  number of words stored, 0..DEPTH.
- partial  out  1  assembler holds 1–3 bytes.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- ferr_seen  out  1  sticky: a byte arrived with rx_ferr=1.

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO pointers, count, byte index and all flags go to 0.
  - word_valid=0, partial=0, overflow=0, ferr_seen=0.
  - word_data is don't-care while word_valid=0. Storage RAM is not reset.
- Assembler state is a 2-bit byte index, LANE0→LANE1→LANE2→LANE3→LANE0. Byte k goes into shift lane k per BIG_ENDIAN.
- Accepting a byte (rx_valid=1, rx_ferr=0):
  - Store the byte in the current lane and advance the index.
  - At LANE3, form the word (3 held bytes + this byte) and push it in the same cycle. The index returns to LANE0.
- Error byte (rx_valid=1, rx_ferr=1):
  - The byte is discarded and the partial word is dropped; the index goes to LANE0.
  - ferr_seen is set.
  - No push occurs, even if the index was LANE3.
- partial = (index != LANE0).
- Push latency: the 4th-byte strobe at edge t makes the word visible as word_valid/word_data after edge t (registered, 1 cycle). count increments on the same edge.
- Pop occurs when word_valid && word_ready. The head advances at the edge and the next word is visible in the following cycle.
- Push with the FIFO full (count==DEPTH) and no pop in that cycle:
  - The word is dropped and overflow is set.
  - The index still returns to LANE0.
  - FIFO contents are unchanged.
- Simultaneous push and pop:
  - When full: both occur, count stays DEPTH, no overflow.
  - When empty: a push cannot be popped in the same cycle because word_valid=0. count becomes 1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is derived from count, never from pointer equality alone.
- Sticky flags clear only on rst or clear. Set and clear in the same cycle: clear wins.
- clear=1:
  - Same effect as reset on the FIFO, index and flags.
  - A same-cycle rx_valid byte is discarded.
  - A same-cycle pop is ignored.
- A byte strobe with rx_valid=0 has no effect regardless of rx_ferr.
- Reset asserted mid-word or with a non-empty FIFO loses all data; the first byte after reset goes to LANE0.

Test Plan:
- Little-endian packing: BIG_ENDIAN=0, send bytes 0x78,0x56,0x34,0x12, word_ready=1 → word_valid pulses one cycle after the 4th strobe with word_data=0x12345678; count goes 0→1→0.
- Big-endian packing: BIG_ENDIAN=1, same bytes → word_data=0x78563412.
- Framing error mid-word: send 0xAA,0xBB, then 0xCC with rx_ferr=1, then 0x01,0x02,0x03,0x04 → ferr_seen=1, partial returns to 0 after the error, single word 0x04030201, no word containing 0xAA.
- Overflow and full-with-pop (DEPTH=16, word_ready=0):
  - Send 17 words (word i = {4{i[7:0]}}) → count=16, overflow=1; head is still 0x00000000 and words 0..15 drain in order.
  - Then fill to 16 again, hold word_ready=1 and push in the same cycle → count stays 16, overflow remains at its prior value.
- Wrap-around: stream 40 words while draining with random word_ready → all 40 words emerge in order, count never exceeds 16, overflow=0.
- Clear and reset mid-operation: 3 words queued plus 2 bytes partial, assert clear with a coincident rx_valid → next cycle count=0, word_valid=0, partial=0, flags 0. The next 4 bytes form a fresh word. Repeat using rst → same result.

Source files
------------

// File: rtl/uart_rx_word_fifo.sv
// uart_rx_word_fifo
// Packs one-cycle byte strobes from a UART receiver into 32-bit words
// and buffers them in a first-word-fall-through FIFO drained with a
// valid/ready handshake. Framing errors and dropped words are recorded
// in sticky flags.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx_data/valid   received byte and its one-cycle strobe
//   rx_ferr         framing error qualifying the same-cycle rx_valid
//   clear           synchronous flush of FIFO, partial word and flags
//   word_data/valid FIFO head word and not-empty indication
//   word_ready      consumer accepts the head word
//   count           words stored, 0..DEPTH
//   partial         assembler holds 1-3 bytes
//   overflow        sticky: completed word dropped, FIFO full
//   ferr_seen       sticky: byte received with rx_ferr=1
module uart_rx_word_fifo #(
    parameter int DEPTH      = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_ferr,
    input  logic                       clear,
    output logic [31:0]                word_data,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       partial,
    output logic                       overflow,
    output logic                       ferr_seen
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE3 = 2'd3;

    logic [1:0]    lane_reg, lane_next;
    logic [7:0]    held_reg [0:2];
    logic [7:0]    lane_byte [0:3];
    logic [31:0]   word_formed;

    logic [31:0]   mem [0:DEPTH-1];
    logic [31:0]   head_reg;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          ferr_reg, ferr_next;

    logic accept, bad, push_req, full, empty, pop, push, drop;

    // A clear in the same cycle swallows any byte strobe.
    assign accept   = rx_valid && !rx_ferr && !clear;
    assign bad      = rx_valid && rx_ferr && !clear;
    assign push_req = accept && (lane_reg == LANE3);
    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign pop      = !empty && word_ready && !clear;
    // A full FIFO can still take a word when the head leaves this cycle.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Lanes 0..2 come from the holding registers, lane 3 is the byte
    // arriving now, so a word is formed and pushed in the same cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            if (gi < 3) begin : g_held
                assign lane_byte[gi] = held_reg[gi];
                always_ff @(posedge clk) begin
                    if (accept && lane_reg == 2'(gi))
                        held_reg[gi] <= rx_data;
                end
            end else begin : g_live
                assign lane_byte[gi] = rx_data;
            end
            if (BIG_ENDIAN) begin : g_be
                assign word_formed[8*(3-gi) +: 8] = lane_byte[gi];
            end else begin : g_le
                assign word_formed[8*gi +: 8] = lane_byte[gi];
            end
        end
    endgenerate

    always_comb begin
        lane_next     = lane_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        ferr_next     = ferr_reg;
        if (clear) begin
            lane_next     = LANE0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
            ferr_next     = 1'b0;
        end else begin
            if (bad)
                lane_next = LANE0;
            else if (accept)
                lane_next = lane_reg + 2'd1;   // LANE3 wraps to LANE0
            if (push)
                wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
            overflow_next = overflow_reg | drop;
            ferr_next     = ferr_reg | bad;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= word_formed;
    end

    // Registered head read, addressed by the next read pointer. When the
    // word being written lands at that address (push into an empty FIFO,
    // or push while popping the last word) the RAM still holds stale data,
    // so the new word is forwarded directly.
    always_ff @(posedge clk) begin
        if (push && wr_ptr_reg == rd_ptr_next)
            head_reg <= word_formed;
        else
            head_reg <= mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_reg     <= LANE0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            lane_reg     <= lane_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            ferr_reg     <= ferr_next;
        end
    end

    assign word_data  = head_reg;
    assign word_valid = !empty;
    assign count      = count_reg;
    assign partial    = (lane_reg != LANE0);
    assign overflow   = overflow_reg;
    assign ferr_seen  = ferr_reg;
endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// Testbench for uart_rx_word_fifo: drives a little-endian and a
// big-endian instance with the same byte stream and checks both against
// a queue-based model every cycle, plus literal expectations.
module tb_uart_rx_word_fifo;
    logic        clk = 1'b0;
    logic        rst, clear;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ferr, word_ready;

    logic [31:0] le_data, be_data;
    logic        le_valid, be_valid;
    logic [4:0]  le_count, be_count;
    logic        le_partial, be_partial, le_ovf, be_ovf, le_ferr, be_ferr;

    always #5 clk = ~clk;

    uart_rx_word_fifo #(.DEPTH(16), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ferr(rx_ferr), .clear(clear), .word_data(le_data),
        .word_valid(le_valid), .word_ready(word_ready), .count(le_count),
        .partial(le_partial), .overflow(le_ovf), .ferr_seen(le_ferr));

    uart_rx_word_fifo #(.DEPTH(16), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ferr(rx_ferr), .clear(clear), .word_data(be_data),
        .word_valid(be_valid), .word_ready(word_ready), .count(be_count),
        .partial(be_partial), .overflow(be_ovf), .ferr_seen(be_ferr));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] q_le[$];
    logic [31:0] q_be[$];
    logic [7:0]  mb [4];
    int          nb = 0;
    bit          m_ovf = 0, m_ferr = 0;
    int          popped = 0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        bit          was_full, m_pop;
        logic [31:0] wle, wbe;
        if (rst || clear) begin
            q_le.delete(); q_be.delete();
            nb = 0; m_ovf = 0; m_ferr = 0;
        end else begin
            was_full = (q_le.size() == 16);
            m_pop    = (q_le.size() != 0) && word_ready;
            if (m_pop) begin
                q_le.delete(0); q_be.delete(0);
                popped++;
            end
            if (rx_valid) begin
                if (rx_ferr) begin
                    nb = 0; m_ferr = 1;
                end else begin
                    mb[nb] = rx_data;
                    nb++;
                    if (nb == 4) begin
                        wle = 0; wbe = 0;
                        for (int k = 0; k < 4; k++) begin
                            wle |= 32'(mb[k]) << (8 * k);
                            wbe |= 32'(mb[k]) << (8 * (3 - k));
                        end
                        if (!was_full || m_pop) begin
                            q_le.push_back(wle); q_be.push_back(wbe);
                        end else begin
                            m_ovf = 1;
                        end
                        nb = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("le_valid", 32'(le_valid), 32'(q_le.size() != 0));
            chk("be_valid", 32'(be_valid), 32'(q_be.size() != 0));
            chk("le_count", 32'(le_count), 32'(q_le.size()));
            chk("be_count", 32'(be_count), 32'(q_be.size()));
            if (q_le.size() != 0) begin
                chk("le_data", le_data, q_le[0]);
                chk("be_data", be_data, q_be[0]);
            end
            chk("partial", {30'd0, be_partial, le_partial}, {30'd0, nb != 0, nb != 0});
            chk("overflow", {30'd0, be_ovf, le_ovf}, {30'd0, m_ovf, m_ovf});
            chk("ferr_seen", {30'd0, be_ferr, le_ferr}, {30'd0, m_ferr, m_ferr});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe);
        rx_data = b; rx_valid = 1'b1; rx_ferr = fe;
        tick();
        rx_valid = 1'b0; rx_ferr = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);   // bytes in LE order
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
    endtask

    bit ready_run;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; clear = 0; rx_data = 0; rx_valid = 0; rx_ferr = 0; word_ready = 0;
        tick(); tick();
        rst = 0; chk_en = 1;
        chk("rst_count", 32'(le_count), 0);
        chk("rst_valid", 32'(le_valid), 0);
        tick();
        $display("txn reset done");

        // Packing in both endiannesses
        word_ready = 1;
        send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
        chk("pack_valid", 32'(le_valid), 1);
        chk("pack_le", le_data, 32'h12345678);
        chk("pack_be", be_data, 32'h78563412);
        chk("pack_count1", 32'(le_count), 1);
        tick();
        chk("pack_count0", 32'(le_count), 0);
        $display("txn pack le=%08h be=%08h", 32'h12345678, 32'h78563412);

        // Framing error mid-word
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        chk("ferr_partial1", 32'(le_partial), 1);
        send_byte(8'hCC, 1);
        chk("ferr_partial0", 32'(le_partial), 0);
        chk("ferr_flag", 32'(le_ferr), 1);
        word_ready = 0;
        send_word(32'h04030201);
        chk("ferr_word", le_data, 32'h04030201);
        chk("ferr_count", 32'(le_count), 1);
        word_ready = 1; tick(); word_ready = 0;
        $display("txn ferr word=%08h", 32'h04030201);

        // Overflow: 17 words into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_word({4{8'(i)}});
        chk("ovf_count", 32'(le_count), 16);
        chk("ovf_flag", 32'(le_ovf), 1);
        chk("ovf_head", le_data, 32'h00000000);
        word_ready = 1;
        for (int i = 0; i < 16; i++) tick();
        word_ready = 0;
        chk("ovf_drained", 32'(le_count), 0);
        $display("txn overflow 17 words sent, 16 drained");

        // Full with simultaneous push and pop
        clear = 1; tick(); clear = 0;
        for (int i = 0; i < 16; i++) send_word({4{8'(i)}});
        send_byte(8'h20, 0); send_byte(8'h21, 0); send_byte(8'h22, 0);
        word_ready = 1;
        send_byte(8'h23, 0);
        word_ready = 0;
        chk("fullpp_count", 32'(le_count), 16);
        chk("fullpp_ovf", 32'(le_ovf), 0);
        chk("fullpp_head", le_data, 32'h01010101);
        word_ready = 1;
        for (int i = 0; i < 16; i++) tick();
        word_ready = 0;
        chk("fullpp_drained", 32'(le_count), 0);
        $display("txn full push+pop count=16");

        // Wrap-around with random ready
        clear = 1; tick(); clear = 0;
        popped = 0; ready_run = 1;
        fork
            begin
                for (int i = 0; i < 40; i++) send_word(32'hA0000000 | 32'(i * 3));
                ready_run = 0;
            end
            begin
                while (ready_run) begin
                    word_ready = ($urandom_range(0, 2) != 0);
                    tick();
                end
            end
        join
        word_ready = 1;
        for (int i = 0; i < 20; i++) tick();
        word_ready = 0;
        chk("wrap_popped", 32'(popped), 40);
        chk("wrap_ovf", 32'(le_ovf), 0);
        $display("txn wrap 40 words popped=%0d", popped);

        // Clear, then reset, mid-operation
        for (int pass = 0; pass < 2; pass++) begin
            send_byte(8'h55, 1);
            for (int i = 0; i < 3; i++) send_word(32'h11111111 * 32'(i + 1));
            send_byte(8'hE0, 0); send_byte(8'hE1, 0);
            rx_data = 8'h99; rx_valid = 1;
            if (pass == 0) clear = 1; else rst = 1;
            tick();
            clear = 0; rst = 0; rx_valid = 0;
            chk("flush_count", 32'(le_count), 0);
            chk("flush_valid", 32'(le_valid), 0);
            chk("flush_partial", 32'(le_partial), 0);
            chk("flush_flags", {30'd0, le_ovf, le_ferr}, 0);
            send_word(32'hDDCCBBAA);
            chk("flush_word", le_data, 32'hDDCCBBAA);
            chk("flush_word_be", be_data, 32'hAABBCCDD);
            word_ready = 1; tick(); word_ready = 0;
            $display("txn flush via %s fresh word=%08h", pass == 0 ? "clear" : "rst", 32'hDDCCBBAA);
        end

        tick();
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
